seg_scan_ctrl: RTL

Scan controller for the eight-digit seven-segment display path. It holds the 32-bit display word (eight 4-bit nibbles) plus decimal points. It generates the 3-bit digit select that drives the downstream 8-to-1 4-bit nibble multiplexer and the active-low digit anodes. Digit slots include dead-time blanking against ghosting, and new data is applied only at frame boundaries so the display never tears.

---
 rtl/seg_scan_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- eight-digit seven-segment scan controller.
//
// Holds the committed 32-bit display word and decimal points. Produces the
// digit select for the downstream 8:1 nibble mux and the active-low anodes.
// Each digit slot starts with DEAD_CYC dark cycles to avoid ghosting. New data
// is committed only at frame boundaries (sel 7->0), so a frame never tears.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   en                scan enable (low: dark, scan held at digit 0)
//   load              one-cycle strobe capturing data_in / dp_in
//   data_in[31:0]     nibble i = digit i
//   dp_in[7:0]        decimal point per digit, active-high
//   disp_word[31:0]   committed display word (mux inputs x0..x7)
//   sel[2:0]          current digit index (mux select)
//   an_n[7:0]         digit anodes, active-low, at most one low
//   dp_n              decimal point of current digit, active-low
//   frame_tick        one-cycle pulse after the sel 7->0 edge
module seg_scan_ctrl #(
  parameter int CLK_DIV    = 50000,
  parameter int DEAD_CYC   = 16,
  parameter int BLANK_LEAD = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  output logic [31:0] disp_word,
  output logic [2:0]  sel,
  output logic [7:0]  an_n,
  output logic        dp_n,
  output logic        frame_tick
);

  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {S_OFF, S_DEAD, S_ON} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    sel_nx;
  logic [31:0]   shadow;
  logic [7:0]    shadow_dp, dp_reg;
  logic          pending;
  logic          slot_end, wrap;
  logic [7:0]    blank;

  assign slot_end = (state != S_OFF) && (cnt == CW'(CLK_DIV - 1));
  // Wrap only happens if the scan keeps running through this edge.
  assign wrap     = en && slot_end && (sel == 3'd7);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sel_nx   = sel;
    if (!en) begin
      state_nx = S_OFF;
      cnt_nx   = '0;
      sel_nx   = 3'd0;
    end else if (state == S_OFF) begin
      cnt_nx   = '0;
      state_nx = (DEAD_CYC == 0) ? S_ON : S_DEAD;
    end else begin
      if (slot_end) begin
        cnt_nx = '0;
        sel_nx = sel + 3'd1;
      end else begin
        cnt_nx = cnt + CW'(1);
      end
      state_nx = (cnt_nx >= CW'(DEAD_CYC)) ? S_ON : S_DEAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_OFF;
      cnt        <= '0;
      sel        <= 3'd0;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      sel        <= sel_nx;
      frame_tick <= wrap;
    end
  end

  // Commit path. While dark (OFF) there is nothing to tear, so loads go
  // straight through and any shadow left over from a scan that was stopped
  // mid-frame is flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_word <= '0;
      dp_reg    <= '0;
      shadow    <= '0;
      shadow_dp <= '0;
      pending   <= 1'b0;
    end else if (load && (state == S_OFF || wrap)) begin
      disp_word <= data_in;
      dp_reg    <= dp_in;
      pending   <= 1'b0;
    end else if (load) begin
      shadow    <= data_in;
      shadow_dp <= dp_in;
      pending   <= 1'b1;
    end else if (pending && (state == S_OFF || wrap)) begin
      disp_word <= shadow;
      dp_reg    <= shadow_dp;
      pending   <= 1'b0;
    end
  end

  // Digit i is a leading zero when nibbles 7..i are all zero; digit 0 never is.
  always_comb begin
    blank = '0;
    for (int i = 1; i < 8; i++)
      blank[i] = (BLANK_LEAD != 0) && ((disp_word >> (4 * i)) == 32'd0);
  end

  always_comb begin
    an_n = 8'hFF;
    dp_n = 1'b1;
    if (state == S_ON && !blank[sel]) begin
      an_n[sel] = 1'b0;
      dp_n      = ~dp_reg[sel];
    end
  end

endmodule
